// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU sharing arbiter: default widths and the ALU opcode map.
package alu_share_arbiter_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int NUM_REQ_DEF = 2;
    localparam int ALU_OP_W    = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_SLT   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_NOR   = 4'd10,
        ALU_PASSA = 4'd11,
        ALU_PASSB = 4'd12,
        ALU_ANDN  = 4'd13,
        ALU_ORN   = 4'd14,
        ALU_XNOR  = 4'd15
    } alu_op_e;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the requesters, the result consumer and the shared ALU arbiter.
interface alu_share_arbiter_if #(
    parameter int XLEN    = 32,
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) ();

    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*XLEN-1:0] req_in1;
    logic [NUM_REQ*XLEN-1:0] req_in2;
    logic [NUM_REQ*4-1:0]    req_op;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [ID_W-1:0]         rsp_id;
    logic [XLEN-1:0]         rsp_data;

    modport master (
        output req_valid, req_in1, req_in2, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_in1, req_in2, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );

endinterface

// File: rtl/alu_share_arbiter_alu.sv
// Purely combinational ALU shared by all requesters; every 4-bit opcode has a defined result.
module alu_share_arbiter_alu
    import alu_share_arbiter_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  alu_op_e         op,
    output logic [XLEN-1:0] result
);

    localparam int SH_W = $clog2(XLEN);

    logic [SH_W-1:0] shamt;

    assign shamt = in2[SH_W-1:0];

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:   result = in1 + in2;
            ALU_SUB:   result = in1 - in2;
            ALU_AND:   result = in1 & in2;
            ALU_OR:    result = in1 | in2;
            ALU_XOR:   result = in1 ^ in2;
            ALU_SLL:   result = in1 << shamt;
            ALU_SRL:   result = in1 >> shamt;
            ALU_SRA:   result = XLEN'($signed(in1) >>> shamt);
            ALU_SLT:   result = {{(XLEN-1){1'b0}}, $signed(in1) < $signed(in2)};
            ALU_SLTU:  result = {{(XLEN-1){1'b0}}, in1 < in2};
            ALU_NOR:   result = ~(in1 | in2);
            ALU_PASSA: result = in1;
            ALU_PASSB: result = in2;
            ALU_ANDN:  result = in1 & ~in2;
            ALU_ORN:   result = in1 | ~in2;
            ALU_XNOR:  result = ~(in1 ^ in2);
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between NUM_REQ requesters through a one-entry operand stage;
// results return in order on a single response channel tagged with the requester id.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_share_arbiter_if.slave  bus
);

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant;
    logic [ID_W-1:0] next_ptr;
    logic            slot_free;
    logic            accept;

    logic            stage_valid;
    logic [ID_W-1:0] stage_id;
    logic [XLEN-1:0] stage_in1;
    logic [XLEN-1:0] stage_in2;
    alu_op_e         stage_op;

    // First valid requester at or after the pointer, wrapping; falls back to the pointer when idle.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                input logic [ID_W-1:0]    ptr);
        logic [ID_W-1:0] pick;
        int              idx;
        pick = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (valid[idx]) pick = ID_W'(idx);
        end
        return pick;
    endfunction

    always_comb begin
        grant     = rr_pick(bus.req_valid, rr_ptr);
        slot_free = !stage_valid || bus.rsp_ready;
        accept    = rst_n && slot_free && bus.req_valid[grant];
        next_ptr  = (int'(grant) == NUM_REQ - 1) ? '0 : grant + ID_W'(1);
    end

    // Gating with rst_n keeps every requester stalled while reset is asserted.
    always_comb begin
        bus.req_ready = '0;
        if (rst_n && slot_free) bus.req_ready[grant] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid <= 1'b0;
            rr_ptr      <= '0;
            stage_id    <= '0;
            stage_in1   <= '0;
            stage_in2   <= '0;
            stage_op    <= ALU_ADD;
        end else if (accept) begin
            stage_valid <= 1'b1;
            rr_ptr      <= next_ptr;
            stage_id    <= grant;
            stage_in1   <= bus.req_in1[grant*XLEN +: XLEN];
            stage_in2   <= bus.req_in2[grant*XLEN +: XLEN];
            stage_op    <= alu_op_e'(bus.req_op[grant*ALU_OP_W +: ALU_OP_W]);
        end else if (bus.rsp_ready) begin
            stage_valid <= 1'b0;
        end
    end

    assign bus.rsp_valid = stage_valid;
    assign bus.rsp_id    = stage_id;

    alu_share_arbiter_alu #(
        .XLEN (XLEN)
    ) u_alu (
        .in1    (stage_in1),
        .in2    (stage_in2),
        .op     (stage_op),
        .result (bus.rsp_data)
    );

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized scoreboard bench for alu_share_arbiter: a driver predicts grants and results from the
// arbitration rules, a separate monitor checks every presented response against the expected queue.
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    localparam int XLEN    = 32;
    localparam int NUM_REQ = 2;
    localparam int ID_W    = 1;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [XLEN-1:0] data;
    } exp_t;

    logic clk;
    logic rst_n;

    alu_share_arbiter_if #(.XLEN(XLEN), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    alu_share_arbiter #(.XLEN(XLEN), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t            sb[$];
    int              checks = 0;
    int              fails  = 0;
    int              rr_model = 0;
    logic            pend_valid [NUM_REQ];
    logic [3:0]      pend_op    [NUM_REQ];
    logic [XLEN-1:0] pend_a     [NUM_REQ];
    logic [XLEN-1:0] pend_b     [NUM_REQ];
    logic            rsp_rdy;
    logic [XLEN-1:0] held_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Behavioural ALU written straight from the opcode meanings.
    function automatic logic [XLEN-1:0] model_alu(input logic [3:0] op, input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (alu_op_e'(op))
            ALU_ADD:   return a + b;
            ALU_SUB:   return a - b;
            ALU_AND:   return a & b;
            ALU_OR:    return a | b;
            ALU_XOR:   return a ^ b;
            ALU_SLL:   return a << sh;
            ALU_SRL:   return a >> sh;
            ALU_SRA:   return XLEN'($signed(a) >>> sh);
            ALU_SLT:   return ($signed(a) < $signed(b)) ? 1 : 0;
            ALU_SLTU:  return (a < b) ? 1 : 0;
            ALU_NOR:   return ~(a | b);
            ALU_PASSA: return a;
            ALU_PASSB: return b;
            ALU_ANDN:  return a & ~b;
            ALU_ORN:   return a | ~b;
            default:   return ~(a ^ b);
        endcase
    endfunction

    task automatic set_req(input int p, input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        pend_valid[p] = 1'b1;
        pend_op[p]    = op;
        pend_a[p]     = a;
        pend_b[p]     = b;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NUM_REQ; i++) pend_valid[i] = 1'b0;
    endtask

    // One clock of stimulus: drive, predict the grant from the pointer rule, record the accept.
    task automatic apply_stimulus();
        int              g;
        int              idx;
        logic            slot_free;
        logic [NUM_REQ-1:0] exp_rdy;
        @(negedge clk);
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_valid[i]           = pend_valid[i];
            bus.req_op[i*4 +: 4]       = pend_valid[i] ? pend_op[i] : 4'($urandom);
            bus.req_in1[i*XLEN +: XLEN] = pend_valid[i] ? pend_a[i] : $urandom;
            bus.req_in2[i*XLEN +: XLEN] = pend_valid[i] ? pend_b[i] : $urandom;
        end
        bus.rsp_ready = rsp_rdy;
        #1;
        g = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (rr_model + k) % NUM_REQ;
            if (g < 0 && pend_valid[idx]) g = idx;
        end
        slot_free = (sb.size() == 0) || rsp_rdy;
        if (g >= 0) begin
            exp_rdy = slot_free ? NUM_REQ'(1) << g : '0;
            check_output("req_ready", XLEN'(bus.req_ready), XLEN'(exp_rdy));
        end else if (!slot_free) begin
            check_output("req_ready_stall", XLEN'(bus.req_ready), '0);
        end
        @(posedge clk);
        if (g >= 0 && slot_free) begin
            sb.push_back('{id: ID_W'(g), data: model_alu(pend_op[g], pend_a[g], pend_b[g])});
            pend_valid[g] = 1'b0;
            rr_model = (g + 1) % NUM_REQ;
        end
    endtask

    // Monitor: response presence must match the outstanding count, contents must match the queue head.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                check_output("rsp_valid", XLEN'(bus.rsp_valid), XLEN'(sb.size() != 0));
                if (bus.rsp_valid && sb.size() != 0) begin
                    check_output("rsp_id", XLEN'(bus.rsp_id), XLEN'(sb[0].id));
                    check_output("rsp_data", bus.rsp_data, sb[0].data);
                    if (bus.rsp_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        rsp_rdy = 1'b1;
        clear_reqs();
        bus.req_valid = '1;
        bus.req_in1 = '0;
        bus.req_in2 = '0;
        bus.req_op = '0;
        bus.rsp_ready = 1'b1;

        // Reset with both requesters asking.
        repeat (3) @(negedge clk);
        #1;
        check_output("reset_req_ready", XLEN'(bus.req_ready), '0);
        check_output("reset_rsp_valid", XLEN'(bus.rsp_valid), '0);
        bus.req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        set_req(0, ALU_XOR, 32'h1234_5678, 32'hFFFF_0000);
        set_req(1, ALU_OR, 32'h0000_00F0, 32'h0000_000F);
        apply_stimulus();
        apply_stimulus();
        repeat (2) apply_stimulus();

        // Single ADD request.
        set_req(0, ALU_ADD, 32'd5, 32'd7);
        apply_stimulus();
        #1;
        check_output("add_data", bus.rsp_data, 32'd12);
        check_output("add_id", XLEN'(bus.rsp_id), '0);
        repeat (2) apply_stimulus();

        // Contention, both requesters always valid.
        for (int n = 0; n < 8; n++) begin
            for (int p = 0; p < NUM_REQ; p++)
                if (!pend_valid[p]) set_req(p, 4'($urandom), $urandom, $urandom);
            apply_stimulus();
        end
        clear_reqs();
        repeat (2) apply_stimulus();

        // Backpressure with a result pending and both requesters waiting.
        set_req(0, ALU_SUB, 32'd100, 32'd1);
        apply_stimulus();
        rsp_rdy = 1'b0;
        set_req(0, ALU_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        set_req(1, ALU_SLL, 32'h0000_0003, 32'd4);
        #1;
        held_data = bus.rsp_data;
        repeat (3) begin
            apply_stimulus();
            #1;
            check_output("held_data", bus.rsp_data, held_data);
        end
        rsp_rdy = 1'b1;
        repeat (4) apply_stimulus();

        // Wrap: requester 1 alone, then both, which must hand the grant back to 0.
        clear_reqs();
        set_req(1, ALU_SUB, 32'h0000_0000, 32'd1);
        apply_stimulus();
        #1;
        check_output("sub_data", bus.rsp_data, 32'hFFFF_FFFF);
        check_output("sub_id", XLEN'(bus.rsp_id), 1);
        set_req(0, ALU_PASSA, 32'hCAFE_0000, 32'd0);
        set_req(1, ALU_PASSB, 32'd0, 32'h0000_BEEF);
        repeat (4) apply_stimulus();

        // Reset while a result is stalled.
        set_req(0, ALU_XNOR, 32'h5555_AAAA, 32'h0F0F_0F0F);
        apply_stimulus();
        rsp_rdy = 1'b0;
        apply_stimulus();
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_output("async_reset_rsp_valid", XLEN'(bus.rsp_valid), '0);
        sb.delete();
        rr_model = 0;
        clear_reqs();
        bus.req_valid = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rsp_rdy = 1'b1;
        repeat (3) apply_stimulus();

        // Randomized traffic and backpressure over all opcodes.
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < NUM_REQ; p++)
                if (!pend_valid[p] && $urandom_range(0, 9) < 6)
                    set_req(p, 4'($urandom_range(0, 15)), $urandom, $urandom);
            rsp_rdy = ($urandom_range(0, 9) < 7);
            apply_stimulus();
        end
        rsp_rdy = 1'b1;
        for (int n = 0; n < 6; n++) apply_stimulus();
        clear_reqs();
        repeat (3) apply_stimulus();
        check_output("scoreboard_drained", XLEN'(sb.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
